risc8_fetch: RTL



---
 rtl/risc8_pkg.sv | 38 +++
 rtl/risc8_stack2.sv | 33 +++
 rtl/risc8_fetch.sv | 131 +++++++++++++
 3 files changed

// File: rtl/risc8_pkg.sv
// Shared constants and opcode decode helpers for the RISC8 fetch/sequencer slice.
package risc8_pkg;

    localparam int INST_W = 12;

    localparam logic [INST_W-1:0] NOP         = 12'h000;
    localparam logic [INST_W-1:0] GOTO_MASK   = 12'hE00;
    localparam logic [INST_W-1:0] GOTO_MATCH  = 12'hA00;
    localparam logic [INST_W-1:0] CALL_MASK   = 12'hF00;
    localparam logic [INST_W-1:0] CALL_MATCH  = 12'h900;
    localparam logic [INST_W-1:0] RETLW_MASK  = 12'hF00;
    localparam logic [INST_W-1:0] RETLW_MATCH = 12'h800;
    localparam logic [INST_W-1:0] SLEEP_MASK  = 12'hFFF;
    localparam logic [INST_W-1:0] SLEEP_MATCH = 12'h003;

    localparam logic [4:0] PCL_ADDR = 5'h02;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_PCL,
        ACT_GOTO,
        ACT_CALL,
        ACT_RETLW,
        ACT_SKIP
    } act_e;

    typedef enum logic {
        ST_RUN,
        ST_SLEEP
    } run_state_e;

    function automatic logic op_match(input logic [INST_W-1:0] word,
                                      input logic [INST_W-1:0] mask,
                                      input logic [INST_W-1:0] match);
        return (word & mask) == match;
    endfunction

endpackage

// File: rtl/risc8_stack2.sv
// Two-entry hardware return stack; a push onto a full stack drops the oldest entry.
module risc8_stack2
    import risc8_pkg::*;
#(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stack0;
    logic [W-1:0] stack1;

    // stack1 is never cleared by a pop, so back-to-back pops both return it
    always_ff @(posedge clk) begin
        if (reset) begin
            stack0 <= '0;
            stack1 <= '0;
        end else if (push) begin
            stack1 <= stack0;
            stack0 <= din;
        end else if (pop) begin
            stack0 <= stack1;
        end
    end

    assign dout = stack0;

endmodule

// File: rtl/risc8_fetch.sv
// Program counter sequencer and execute-stage instruction register for RISC8.
// Optional SLEEP handling is built when RISC8_SLEEP_EN is defined.
//   state    | meaning
//   ST_RUN   | fetching one instruction per cycle
//   ST_SLEEP | pc held, NOP issued, waiting for wake
module risc8_fetch
    import risc8_pkg::*;
#(
    parameter int                  PC_WIDTH  = 11,
    parameter logic [PC_WIDTH-1:0] RESET_VEC = {PC_WIDTH{1'b1}}
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [PC_WIDTH-1:0]  paddr,
    input  logic [INST_W-1:0]    pdata,
    output logic [INST_W-1:0]    inst,
    input  logic                 skip,
    input  logic                 pcl_we,
    input  logic [7:0]           pcl_din,
    input  logic [PC_WIDTH-10:0] pa,
    output logic                 sleeping,
    input  logic                 wake
);

    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_nxt;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] stack_dout;
    logic [INST_W-1:0]   inst_nxt;
    logic                push;
    logic                pop;
    logic                hold;
    act_e                act;

    assign pc_inc = pc + PC_WIDTH'(1);
    assign paddr  = pc;

`ifdef RISC8_SLEEP_EN
    run_state_e state;
    run_state_e state_nxt;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (op_match(inst, SLEEP_MASK, SLEEP_MATCH) && !wake) state_nxt = ST_SLEEP;
            ST_SLEEP: if (wake) state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // The wake cycle still holds pc so fetch restarts at the word after SLEEP
    assign sleeping = (state == ST_SLEEP);
    assign hold     = sleeping || (state_nxt == ST_SLEEP);
`else
    logic unused_wake;
    assign unused_wake = wake;
    assign sleeping    = 1'b0;
    assign hold        = 1'b0;
`endif

    // Flushed NOPs decode to ACT_NONE, so a branch can never fire from a shadow slot
    always_comb begin
        act = ACT_NONE;
        if (pcl_we)                                     act = ACT_PCL;
        else if (op_match(inst, GOTO_MASK, GOTO_MATCH)) act = ACT_GOTO;
        else if (op_match(inst, CALL_MASK, CALL_MATCH)) act = ACT_CALL;
        else if (op_match(inst, RETLW_MASK, RETLW_MATCH)) act = ACT_RETLW;
        else if (skip)                                  act = ACT_SKIP;
    end

    always_comb begin
        pc_nxt   = pc_inc;
        inst_nxt = pdata;
        push     = 1'b0;
        pop      = 1'b0;
        if (hold) begin
            pc_nxt   = pc;
            inst_nxt = NOP;
        end else begin
            case (act)
                ACT_PCL: begin
                    pc_nxt   = {pa, 1'b0, pcl_din};
                    inst_nxt = NOP;
                end
                ACT_GOTO: begin
                    pc_nxt   = {pa, inst[8:0]};
                    inst_nxt = NOP;
                end
                ACT_CALL: begin
                    push     = 1'b1;
                    pc_nxt   = {pa, 1'b0, inst[7:0]};
                    inst_nxt = NOP;
                end
                ACT_RETLW: begin
                    pop      = 1'b1;
                    pc_nxt   = stack_dout;
                    inst_nxt = NOP;
                end
                ACT_SKIP: inst_nxt = NOP;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc   <= RESET_VEC;
            inst <= NOP;
        end else begin
            pc   <= pc_nxt;
            inst <= inst_nxt;
        end
    end

    risc8_stack2 #(
        .W (PC_WIDTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc),
        .dout  (stack_dout)
    );

endmodule
